pipe_stage_buf: RTL and testbench

Generic, parametrised pipeline stage register for the MINI-RISC pipeline. It replaces the fixed-width FD/DE/EW registers with one block that can sit between any two stages.
- Carries a DATA_W-bit payload under a valid/ready handshake.
- Supports stall (hold) and flush (squash to NOP).
- Has an optional 2-entry skid buffer, so in_ready has no combinational path from out_ready.
- Exposes occupancy and a saturating back-pressure cycle counter for performance debug.

---
 rtl/pipe_pkg.sv | 12 +
 rtl/sat_counter.sv | 19 +
 rtl/pipe_stage_buf.sv | 114 +++++++++++
 tb/tb_pipe_stage_buf.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the MINI-RISC pipeline stage buffer.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [15:0] PIPE_NOP = 16'h0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic pipeline stage register: valid/ready, stall, flush,
// optional 2-entry skid buffer and back-pressure counter.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter logic [DATA_W-1:0] NOP_VALUE = DATA_W'(PIPE_NOP),
  parameter int                SKID      = 1,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bp_cycles
);

  state_t            state, state_n;
  logic [DATA_W-1:0] main, main_n;
  logic [DATA_W-1:0] skid, skid_n;
  logic              out_fire;
  logic              in_fire;
  logic              bp_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_EMPTY;
      main  <= NOP_VALUE;
      skid  <= NOP_VALUE;
    end else begin
      state <= state_n;
      main  <= main_n;
      skid  <= skid_n;
    end
  end

  always_comb begin
    out_valid = (state != ST_EMPTY) && !flush;
    out_fire  = out_valid && out_ready && !stall;
    if (SKID != 0) begin
      in_ready = (state != ST_FULL) && !stall && !flush;
    end else begin
      // Single entry: a new payload fits only if the head leaves now.
      in_ready = !stall && !flush
               && ((state == ST_EMPTY) || out_fire);
    end
    in_fire = in_valid && in_ready;
  end

  always_comb begin
    state_n = state;
    main_n  = main;
    skid_n  = skid;
    if (flush) begin
      state_n = ST_EMPTY;
      main_n  = NOP_VALUE;
      skid_n  = NOP_VALUE;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            state_n = ST_HALF;
            main_n  = in_data;
          end
        end
        ST_HALF: begin
          if (in_fire && out_fire) begin
            main_n = in_data;
          end else if (in_fire) begin
            state_n = ST_FULL;
            skid_n  = in_data;
          end else if (out_fire) begin
            state_n = ST_EMPTY;
            main_n  = NOP_VALUE;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_n = ST_HALF;
            main_n  = skid;
            skid_n  = NOP_VALUE;
          end
        end
        default: begin
          state_n = ST_EMPTY;
          main_n  = NOP_VALUE;
          skid_n  = NOP_VALUE;
        end
      endcase
    end
  end

  assign out_data  = main;
  assign occupancy = 2'(state);
  assign bp_inc    = (out_valid && !out_ready)
                   || (stall && (state != ST_EMPTY));

  sat_counter #(
    .W (CNT_W)
  ) u_bp_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (bp_inc),
    .count (bp_cycles)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Randomized + directed bench for pipe_stage_buf against a queue model.
module tb_pipe_stage_buf;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic        in_valid, out_ready;
  logic [15:0] in_data;
  logic        in_ready, out_valid;
  logic [15:0] out_data;
  logic [1:0]  occupancy;
  logic [15:0] bp_cycles;
  logic        in_ready_s, out_valid_s;
  logic [15:0] out_data_s;
  logic [1:0]  occupancy_s;
  logic [1:0]  bp_cycles_s;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  logic [15:0] q[$];
  int          cnt;
  bit          seen_cafe = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(
    .DATA_W(16), .NOP_VALUE(16'h0000), .SKID(1), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .occupancy(occupancy),
    .bp_cycles(bp_cycles)
  );

  pipe_stage_buf #(
    .DATA_W(16), .NOP_VALUE(16'h0000), .SKID(1), .CNT_W(2)
  ) dut_s (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .out_data(out_data_s), .occupancy(occupancy_s),
    .bp_cycles(bp_cycles_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [15:0] d,
                       input bit ordy, input bit st, input bit fl);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    stall     = st;
    flush     = fl;
  endtask

  // One clock: check outputs mid-cycle, then advance the model.
  task automatic cycle();
    bit ov, ir, of, inf, inc;
    int n;
    @(negedge clk);
    n   = q.size();
    ov  = (n > 0) && !flush;
    ir  = (n < 2) && !stall && !flush;
    of  = ov && out_ready && !stall;
    inf = in_valid && ir;
    inc = (ov && !out_ready) || (stall && n > 0);
    if (chk_en) begin
      chk("out_valid", 32'(out_valid), 32'(ov));
      chk("in_ready", 32'(in_ready), 32'(ir));
      chk("out_data", 32'(out_data), (n > 0) ? 32'(q[0]) : 32'h0);
      chk("occupancy", 32'(occupancy), 32'(n));
      chk("bp_cycles", 32'(bp_cycles), 32'(cnt));
      chk("bp_sat", 32'(bp_cycles_s), (cnt > 3) ? 32'd3 : 32'(cnt));
      chk("occ_small", 32'(occupancy_s), 32'(n));
      if (out_valid && out_data == 16'hCAFE) seen_cafe = 1;
    end
    @(posedge clk);
    #1;
    if (reset) begin
      q.delete();
      cnt = 0;
    end else begin
      if (flush) begin
        q.delete();
      end else begin
        if (of) void'(q.pop_front());
        if (inf) q.push_back(in_data);
      end
      if (inc) cnt++;
    end
    chk_en = 1;
  endtask

  initial begin
    int base;
    cnt = 0;
    reset = 1;
    drive(1, 16'h7777, 0, 0, 0);
    cycle();
    cycle();
    reset = 0;

    drive(1, 16'h1111, 1, 0, 0); cycle();
    drive(1, 16'h2222, 1, 0, 0); cycle();
    drive(1, 16'h3333, 1, 0, 0); cycle();
    drive(0, 16'h0000, 1, 0, 0); cycle();
    chk("stream_bp", 32'(bp_cycles), 32'd0);
    cycle();

    drive(1, 16'hA001, 0, 0, 0); cycle();
    drive(1, 16'hA002, 0, 0, 0); cycle();
    drive(1, 16'hA003, 0, 0, 0); cycle();
    chk("skid_full", 32'(occupancy), 32'd2);
    chk("skid_ready", 32'(in_ready), 32'd0);
    drive(1, 16'hA003, 1, 0, 0); cycle();
    cycle();
    drive(0, 16'h0000, 1, 0, 0);
    repeat (3) cycle();

    drive(1, 16'hBEEF, 0, 0, 0); cycle();
    drive(1, 16'hBEF0, 0, 0, 0); cycle();
    drive(1, 16'hCAFE, 0, 0, 1); cycle();
    drive(0, 16'h0000, 1, 0, 0); cycle();
    chk("flush_occ", 32'(occupancy), 32'd0);
    chk("flush_data", 32'(out_data), 32'h0);
    repeat (2) cycle();
    chk("cafe_never", 32'(seen_cafe), 32'd0);

    drive(1, 16'h5A5A, 0, 0, 0); cycle();
    base = cnt;
    drive(0, 16'h0000, 1, 1, 0);
    repeat (3) cycle();
    chk("stall_bp3", 32'(cnt - base), 32'd3);
    chk("stall_hold", 32'(out_data), 32'h5A5A);
    drive(0, 16'h0000, 1, 0, 0);
    repeat (2) cycle();
    chk("stall_drain", 32'(occupancy), 32'd0);

    drive(1, 16'h0042, 0, 0, 0);
    repeat (6) cycle();
    chk("sat_hold", 32'(bp_cycles_s), 32'd3);

    reset = 1; cycle(); reset = 0;
    chk("reset_bp", 32'(bp_cycles), 32'd0);

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1) == 1, 16'($urandom),
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 19) == 0);
      cycle();
    end
    drive(0, 16'h0000, 1, 0, 0);
    repeat (3) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
